// File: rtl/mux_n_pipe.sv
// N-input operand selector with a registered two-entry skid output stage (valid/ready).
// Define MUX_N_PIPE_PARITY_EN to add an even-parity bit (parity_o) carried with each word.
module mux_n_pipe #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 3,
  parameter int SEL_W  = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_IN*WIDTH-1:0] data_i,
  input  logic [SEL_W-1:0]        select_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic                    flush_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [WIDTH-1:0]        data_o,
  output logic [SEL_W-1:0]        sel_o,
  output logic [1:0]              count_o
`ifdef MUX_N_PIPE_PARITY_EN
  ,
  output logic                    parity_o
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t state_reg, state_next;
  logic   in_ready_reg;
  logic   accept, pop;
  logic   load_main, load_skid, move_skid;

  logic [WIDTH-1:0] in_words [NUM_IN];
  logic [SEL_W-1:0] eff_sel;
  logic [WIDTH-1:0] new_word;

  logic [WIDTH-1:0] main_data_reg, skid_data_reg;
  logic [SEL_W-1:0] main_sel_reg,  skid_sel_reg;

  generate
    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_split
      assign in_words[gi] = data_i[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Out-of-range selects clamp to the highest input rather than reading zero.
  always_comb begin
    eff_sel = select_i;
    if (32'(select_i) >= NUM_IN)
      eff_sel = SEL_W'(NUM_IN - 1);
  end

  always_comb begin
    new_word = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (eff_sel == SEL_W'(k))
        new_word = in_words[k];
    end
  end

  assign accept = in_valid_i & in_ready_reg;
  assign pop    = out_valid_o & out_ready_i;

  // State register; in_ready is registered from the next state so it has no path from out_ready_i.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg    <= ST_EMPTY;
      in_ready_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      in_ready_reg <= (state_next != ST_FULL);
    end
  end

  // Next-state and datapath control; flush overrides any accept or pop in the same cycle.
  always_comb begin
    state_next = state_reg;
    load_main  = 1'b0;
    load_skid  = 1'b0;
    move_skid  = 1'b0;
    if (flush_i) begin
      state_next = ST_EMPTY;
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          if (accept) begin
            state_next = ST_ONE;
            load_main  = 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && pop) begin
            load_main = 1'b1;
          end else if (accept) begin
            state_next = ST_FULL;
            load_skid  = 1'b1;
          end else if (pop) begin
            state_next = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop) begin
            state_next = ST_ONE;
            move_skid  = 1'b1;
          end
        end
        default: state_next = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    out_valid_o = (state_reg != ST_EMPTY);
    in_ready_o  = in_ready_reg;
    case (state_reg)
      ST_ONE:  count_o = 2'd1;
      ST_FULL: count_o = 2'd2;
      default: count_o = 2'd0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      main_data_reg <= '0;
      main_sel_reg  <= '0;
      skid_data_reg <= '0;
      skid_sel_reg  <= '0;
    end else begin
      if (load_main) begin
        main_data_reg <= new_word;
        main_sel_reg  <= eff_sel;
      end else if (move_skid) begin
        main_data_reg <= skid_data_reg;
        main_sel_reg  <= skid_sel_reg;
      end
      if (load_skid) begin
        skid_data_reg <= new_word;
        skid_sel_reg  <= eff_sel;
      end
    end
  end

  assign data_o = main_data_reg;
  assign sel_o  = main_sel_reg;

`ifdef MUX_N_PIPE_PARITY_EN
  logic main_par_reg, skid_par_reg;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      main_par_reg <= 1'b0;
      skid_par_reg <= 1'b0;
    end else begin
      if (load_main)
        main_par_reg <= ^new_word;
      else if (move_skid)
        main_par_reg <= skid_par_reg;
      if (load_skid)
        skid_par_reg <= ^new_word;
    end
  end

  assign parity_o = main_par_reg;
`endif

endmodule

// File: tb/tb_mux_n_pipe.sv
// Directed bench for mux_n_pipe: stimulus pushes expected words into a scoreboard,
// a negedge monitor pops and compares every word the DUT hands downstream.
module tb_mux_n_pipe;

  localparam int WIDTH  = 32;
  localparam int NUM_IN = 3;
  localparam int SEL_W  = 2;

  logic                    clk_i;
  logic                    rst_i;
  logic [NUM_IN*WIDTH-1:0] data_i;
  logic [SEL_W-1:0]        select_i;
  logic                    in_valid_i;
  logic                    in_ready_o;
  logic                    flush_i;
  logic                    out_valid_o;
  logic                    out_ready_i;
  logic [WIDTH-1:0]        data_o;
  logic [SEL_W-1:0]        sel_o;
  logic [1:0]              count_o;
`ifdef MUX_N_PIPE_PARITY_EN
  logic                    parity_o;
`endif

  mux_n_pipe #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .data_i      (data_i),
    .select_i    (select_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .flush_i     (flush_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .data_o      (data_o),
    .sel_o       (sel_o),
    .count_o     (count_o)
`ifdef MUX_N_PIPE_PARITY_EN
    ,
    .parity_o    (parity_o)
`endif
  );

  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic [SEL_W-1:0] s;
  } exp_t;

  exp_t             sb_q [$];
  exp_t             mon_e;
  logic [WIDTH-1:0] exp_d;
  logic [SEL_W-1:0] exp_s;
  logic [WIDTH-1:0] d0, d1, d2;
  int               n_checks;
  int               n_fail;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  assign data_i = {d2, d1, d0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic put(input logic [SEL_W-1:0] sel, input logic [WIDTH-1:0] ed, input logic [SEL_W-1:0] es);
    in_valid_i = 1'b1;
    select_i   = sel;
    exp_d      = ed;
    exp_s      = es;
  endtask

  task automatic idle();
    in_valid_i = 1'b0;
  endtask

  // Monitor: a word leaves on the edge after a negedge with valid & ready; flush/reset drop everything.
  always @(negedge clk_i) begin
    if (!rst_i || flush_i) begin
      sb_q.delete();
    end else begin
      if (out_valid_o && out_ready_i) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_underflow: got data %h, required no output", data_o);
        end else begin
          mon_e = sb_q.pop_front();
          $display("pop data=%h sel=%0d", data_o, sel_o);
          check("sb_data", data_o, mon_e.d);
          check("sb_sel", 32'(sel_o), 32'(mon_e.s));
`ifdef MUX_N_PIPE_PARITY_EN
          check("sb_parity", 32'(parity_o), 32'(^mon_e.d));
`endif
        end
      end
      if (in_valid_i && in_ready_o)
        sb_q.push_back({exp_d, exp_s});
    end
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_i = 1'b0; in_valid_i = 1'b0; select_i = '0; flush_i = 1'b0; out_ready_i = 1'b0;
    d0 = '0; d1 = '0; d2 = '0; exp_d = '0; exp_s = '0;

    #12;
    check("rst_valid", 32'(out_valid_o), 0);
    check("rst_count", 32'(count_o), 0);
    check("rst_ready", 32'(in_ready_o), 0);
    check("rst_data", data_o, 0);
    check("rst_sel", 32'(sel_o), 0);
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    check("rel_ready_before_edge", 32'(in_ready_o), 0);
    cyc();
    check("rel_ready_after_edge", 32'(in_ready_o), 1);

    // Select 0,1,2 then clamp with select 3
    d0 = 32'h11111111; d1 = 32'h22222222; d2 = 32'h33333333;
    out_ready_i = 1'b1;
    put(2'd0, 32'h11111111, 2'd0); cyc();
    check("sel0_valid", 32'(out_valid_o), 1);
    check("sel0_data", data_o, 32'h11111111);
    check("sel0_count", 32'(count_o), 1);
    put(2'd1, 32'h22222222, 2'd1); cyc();
    check("sel1_data", data_o, 32'h22222222);
    check("sel1_count", 32'(count_o), 1);
    put(2'd2, 32'h33333333, 2'd2); cyc();
    check("sel2_data", data_o, 32'h33333333);
    check("sel2_count", 32'(count_o), 1);
    d2 = 32'hDEADBEEF;
    put(2'd3, 32'hDEADBEEF, 2'd2); cyc();
    check("clamp_data", data_o, 32'hDEADBEEF);
    check("clamp_sel", 32'(sel_o), 2);
    idle(); cyc();
    check("drain_valid", 32'(out_valid_o), 0);
    check("drain_count", 32'(count_o), 0);

    // Backpressure fills the skid entry
    out_ready_i = 1'b0;
    d0 = 32'h1; put(2'd0, 32'h1, 2'd0); cyc();
    check("bp_a_count", 32'(count_o), 1);
    check("bp_a_ready", 32'(in_ready_o), 1);
    check("bp_a_data", data_o, 32'h1);
    d0 = 32'h2; put(2'd0, 32'h2, 2'd0); cyc();
    check("bp_b_count", 32'(count_o), 2);
    check("bp_b_ready", 32'(in_ready_o), 0);
    check("bp_b_data", data_o, 32'h1);
    idle(); cyc();
    check("bp_hold_data", data_o, 32'h1);
    check("bp_hold_count", 32'(count_o), 2);
    out_ready_i = 1'b1; cyc();
    check("bp_pop1_count", 32'(count_o), 1);
    check("bp_pop1_data", data_o, 32'h2);
    check("bp_pop1_ready", 32'(in_ready_o), 1);
    cyc();
    check("bp_pop2_count", 32'(count_o), 0);
    check("bp_pop2_valid", 32'(out_valid_o), 0);

    // Accept and pop in the same cycle while holding one word
    d0 = 32'h5; put(2'd0, 32'h5, 2'd0); cyc();
    check("ap_first_data", data_o, 32'h5);
    d0 = 32'h6; put(2'd0, 32'h6, 2'd0); cyc();
    check("ap_count", 32'(count_o), 1);
    check("ap_data", data_o, 32'h6);
    idle(); cyc();
    check("ap_drain_count", 32'(count_o), 0);

    // Flush while full, with a word offered
    out_ready_i = 1'b0;
    d0 = 32'hA; put(2'd0, 32'hA, 2'd0); cyc();
    d0 = 32'hB; put(2'd0, 32'hB, 2'd0); cyc();
    check("fl_full_count", 32'(count_o), 2);
    d0 = 32'h7; put(2'd0, 32'h7, 2'd0); flush_i = 1'b1; cyc();
    check("fl_valid", 32'(out_valid_o), 0);
    check("fl_count", 32'(count_o), 0);
    check("fl_ready", 32'(in_ready_o), 1);
    flush_i = 1'b0; idle(); out_ready_i = 1'b1; cyc();
    check("fl_after_valid", 32'(out_valid_o), 0);
    check("fl_retain_data", data_o, 32'hA);

    // Flush in ONE discards a simultaneous accept and pop
    d0 = 32'h9; put(2'd0, 32'h9, 2'd0); cyc();
    check("fl1_count", 32'(count_o), 1);
    d0 = 32'h7; put(2'd0, 32'h7, 2'd0); flush_i = 1'b1; cyc();
    check("fl1_valid", 32'(out_valid_o), 0);
    check("fl1_count0", 32'(count_o), 0);
    flush_i = 1'b0; idle(); cyc();
    check("fl1_after_valid", 32'(out_valid_o), 0);
    check("fl1_no_capture", data_o, 32'h9);

    // Parity word, then async reset while full
    d0 = 32'h7; put(2'd0, 32'h7, 2'd0); cyc();
    check("par_data", data_o, 32'h7);
`ifdef MUX_N_PIPE_PARITY_EN
    check("par_bit", 32'(parity_o), 1);
`endif
    out_ready_i = 1'b0;
    d0 = 32'hC; put(2'd0, 32'hC, 2'd0); cyc();
    check("ar_full_count", 32'(count_o), 2);
    idle();
    #1;
    rst_i = 1'b0;
    #1;
    check("ar_valid", 32'(out_valid_o), 0);
    check("ar_count", 32'(count_o), 0);
    check("ar_ready", 32'(in_ready_o), 0);
    check("ar_data", data_o, 0);
    #10;
    rst_i = 1'b1;
    cyc();
    check("ar_rel_ready", 32'(in_ready_o), 1);
    check("ar_rel_valid", 32'(out_valid_o), 0);

    cyc();
    check("sb_empty_at_end", 32'(sb_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_n_pipe.md
Name: mux_n_pipe

Overview:
- Parametrised N-input, W-bit operand selector with a registered output stage and a valid/ready handshake.
- Successor to the combinational 3:1 operand/forwarding mux in the pipelined datapath.
- Selection happens at input acceptance. The chosen word is held in a two-entry skid buffer, so the stage can sit between pipeline registers under stall and flush.
- Selected word appears one cycle after acceptance.

Parameters:
- WIDTH, 32, data word width in bits.
- NUM_IN, 3, number of data inputs; legal range 2..16.
- SEL_W, 2, select width; must satisfy 2**SEL_W >= NUM_IN.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous active-low reset.
- data_i  input  NUM_IN*WIDTH  flattened inputs; input k at bits [k*WIDTH +: WIDTH].
- select_i  input  SEL_W  binary select, sampled on acceptance.
- in_valid_i  input  1  upstream word/select valid.
- in_ready_o  output  1  stage can accept.
- flush_i  input  1  synchronous discard of all held words.
- out_valid_o  output  1  data_o valid.
- out_ready_i  input  1  downstream accepts.
- data_o  output  WIDTH  selected word.
- sel_o  output  SEL_W  effective (clamped) select used for data_o.
- count_o  output  2  entries held (0..2).

Behaviour:
- Reset (rst_i low, asynchronous):
  - State EMPTY.
  - out_valid_o=0, data_o=0, sel_o=0, count_o=0, in_ready_o=0.
  - in_ready_o rises on the first clock edge after rst_i deasserts.
- Effective select:
  - eff = select_i if select_i < NUM_IN, else NUM_IN-1 (clamp to highest input).
  - Word = data_i[eff*WIDTH +: WIDTH].
- Handshakes:
  - Accept = in_valid_i & in_ready_o.
  - Pop = out_valid_o & out_ready_i.
- in_ready_o is a registered output: 1 unless state is FULL. It has no combinational path from out_ready_i.
- Storage: main register drives data_o/sel_o; skid register holds a second word.
- State transitions (evaluated at the rising edge):
  - EMPTY: accept -> ONE, main loaded.
  - ONE:
    - accept & pop -> ONE, main reloaded with the new word.
    - accept & !pop -> FULL, skid loaded.
    - pop & !accept -> EMPTY.
    - neither -> hold.
  - FULL: no accept possible. pop -> ONE, skid moves to main. Otherwise hold.
- Latency: accept at edge n -> out_valid_o=1 and data_o valid after edge n (visible cycle n+1). Throughput: 1 word/cycle with out_ready_i held high.
- Stability: while out_valid_o=1 and out_ready_i=0, data_o and sel_o hold unchanged.
- Ordering: strict FIFO; the skid word never overtakes the main word.
- count_o: EMPTY=0, ONE=1, FULL=2; updates with state.
- flush_i (synchronous, highest priority):
  - Next state EMPTY; count_o=0; out_valid_o=0 next cycle.
  - Any accept or pop in the same cycle is discarded (no word captured).
  - in_ready_o=1 next cycle.
  - data_o/sel_o retain their last value (don't-care while invalid).
- Reset mid-operation: immediate return to reset values; held words lost.
- Values of data_i/select_i while in_valid_i=0 have no effect.

Optional Feature:
- MUX_N_PIPE_PARITY_EN defined:
  - Adds output port parity_o (1 bit) = XOR of data_o bits (even parity).
  - Computed at acceptance and carried in the main and skid entries alongside each word.
  - Resets to 0; held stable with data_o.
- Not defined: port parity_o absent; no parity storage.

Test Plan:
- Reset release, NUM_IN=3: data0=0x11111111, data1=0x22222222, data2=0x33333333, select 0,1,2 on consecutive cycles, out_ready_i=1 -> data_o 0x11111111, 0x22222222, 0x33333333 one cycle after each accept; count_o=1 steady.
- Clamp: select_i=2'b11, NUM_IN=3, data2=0xDEADBEEF -> data_o=0xDEADBEEF, sel_o=2.
- Backpressure: out_ready_i=0, accept words A=0x1 and B=0x2 -> count_o=2, in_ready_o=0, data_o=0x1 held. Raise out_ready_i -> data_o=0x1, then 0x2, count_o 2->1->0.
- Simultaneous accept+pop in ONE: hold 0x5, present 0x6 with out_ready_i=1 -> count_o stays 1, data_o=0x6 next cycle.
- Flush while FULL with in_valid_i=1 carrying 0x7 -> next cycle out_valid_o=0, count_o=0, in_ready_o=1; 0x7 never appears on data_o.
- Async reset asserted mid-stream between clock edges -> out_valid_o=0, count_o=0, in_ready_o=0 immediately. With MUX_N_PIPE_PARITY_EN: data 0x00000007 -> parity_o=1.
